// File: rtl/astar_pkg.sv
// astar_pkg: shared mode encodings, default widths and per-op metadata layout for the astar distance datapath
package astar_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    localparam int DEF_A_W   = 15;
    localparam int DEF_B_W   = 22;
    localparam int DEF_ACC_W = 48;
    localparam int DEF_TAG_W = 8;

    typedef struct packed {
        logic                 mode;
        logic                 clr;
        logic [DEF_TAG_W-1:0] tag;
    } mul_op_t;

endpackage

// File: rtl/astar_dist_mul_pipe_if.sv
// astar_dist_mul_pipe_if: operand/result handshake bundle between the operand generator, the multiplier and the comparator
interface astar_dist_mul_pipe_if
    import astar_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int TAG_W = DEF_TAG_W
);

    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_mode;
    logic             in_clr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic [ACC_W-1:0] acc_q;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_clr, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, acc_q
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_clr, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, acc_q
    );

endinterface

// File: rtl/astar_pipe_ctrl.sv
// astar_pipe_ctrl: stage valid-bit shift register and the global advance enable shared by every pipeline stage
module astar_pipe_ctrl #(
    parameter int NUM_STAGE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
    output logic en,
    output logic in_ready,
    output logic fin_valid,
    output logic out_valid
);

    logic [NUM_STAGE-1:0] v;
    logic [NUM_STAGE:0]   chain;

    assign chain     = {v, in_valid};
    assign out_valid = chain[NUM_STAGE];
    assign fin_valid = chain[NUM_STAGE-1];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    // valid bits move as one block; bubbles are held in place while stalled
    always_ff @(posedge clk)
        if (reset)
            v <= '0;
        else if (en)
            v <= chain[NUM_STAGE-1:0];

endmodule

// File: rtl/astar_dist_mul_pipe.sv
// astar_dist_mul_pipe: pipelined signed x unsigned multiplier with optional accumulate and valid/ready backpressure
module astar_dist_mul_pipe
    import astar_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int P_W       = A_W + B_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int NUM_STAGE = 3,
    parameter int TAG_W     = DEF_TAG_W
) (
    input logic clk,
    input logic reset,
    astar_dist_mul_pipe_if.slave bus
);

    typedef struct packed {
        logic             mode;
        logic             clr;
        logic [TAG_W-1:0] tag;
    } op_t;

    logic                  en;
    logic                  fin_valid;
    logic signed [P_W-1:0] a_x;
    logic signed [P_W-1:0] b_x;
    logic signed [P_W-1:0] prod;
    logic [ACC_W-1:0]      ext_p;
    logic [ACC_W-1:0]      fin_p;
    logic [ACC_W-1:0]      base;
    logic [ACC_W-1:0]      sum;
    logic [ACC_W-1:0]      out_data_q;
    logic [ACC_W-1:0]      acc;
    logic [TAG_W-1:0]      out_tag_q;
    op_t                   in_op;
    op_t                   fin_op;

    astar_pipe_ctrl #(.NUM_STAGE(NUM_STAGE)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .en        (en),
        .in_ready  (bus.in_ready),
        .fin_valid (fin_valid),
        .out_valid (bus.out_valid)
    );

    // B is zero-extended so the signed multiply treats it as unsigned; the product is exact in P_W bits
    assign a_x   = P_W'($signed(bus.in_a));
    assign b_x   = P_W'({1'b0, bus.in_b});
    assign prod  = a_x * b_x;
    assign ext_p = ACC_W'(prod);
    assign in_op = '{mode: bus.in_mode, clr: bus.in_clr, tag: bus.in_tag};

    if (NUM_STAGE == 1) begin : g_direct
        assign fin_p  = ext_p;
        assign fin_op = in_op;
    end else begin : g_pipe
        logic [ACC_W-1:0] p_q [NUM_STAGE-1];
        op_t              m_q [NUM_STAGE-1];
        // product and metadata ride alongside the valid bits; data needs no reset because valid gates it
        always_ff @(posedge clk)
            if (en) begin
                p_q[0] <= ext_p;
                m_q[0] <= in_op;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    p_q[i] <= p_q[i-1];
                    m_q[i] <= m_q[i-1];
                end
            end
        assign fin_p  = p_q[NUM_STAGE-2];
        assign fin_op = m_q[NUM_STAGE-2];
    end

    assign base = fin_op.clr ? '0 : acc;
    assign sum  = base + fin_p;

    // final stage: results and the accumulator change only when a valid op is actually captured
    always_ff @(posedge clk)
        if (reset) begin
            out_data_q <= '0;
            out_tag_q  <= '0;
            acc        <= '0;
        end else if (en && fin_valid) begin
            out_data_q <= (fin_op.mode == MODE_MAC) ? sum : fin_p;
            out_tag_q  <= fin_op.tag;
            if (fin_op.mode == MODE_MAC)
                acc <= sum;
        end

    assign bus.out_data = out_data_q;
    assign bus.out_tag  = out_tag_q;
    assign bus.acc_q    = acc;

endmodule

// File: doc/astar_dist_mul_pipe.md
Name: astar_dist_mul_pipe

Overview:
- Parametrised, pipelined signed×unsigned multiplier for the astar distance datapath. Successor to the single-cycle combinational distance multipliers.
- Adds configurable operand widths, configurable pipeline depth, a valid/ready handshake with full backpressure, a passthrough tag, and a multiply-accumulate mode.
- Sits between the astar heuristic operand generator and the distance comparator inside the astar task unit.

Parameters:
- A_W, 15: signed operand A width.
- B_W, 22: unsigned operand B width.
- P_W, A_W+B_W: raw product width (derived; do not override).
- ACC_W, 48: result/accumulator width. Must be ≥ P_W.
- NUM_STAGE, 3: pipeline latency in cycles. Must be ≥ 1.
- TAG_W, 8: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_a  in  A_W  signed multiplicand
- in_b  in  B_W  unsigned multiplier, zero-extended before multiply
- in_mode  in  1  0 = MUL, 1 = MAC
- in_clr  in  1  MAC only: treat the accumulator as 0 before adding
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  ACC_W  signed result
- out_tag  out  TAG_W  tag of this result
- acc_q  out  ACC_W  current accumulator value (debug)

Behaviour:
- Reset (synchronous, clk edge with reset=1): all stage valid bits=0, out_valid=0, out_data=0, out_tag=0, acc_q=0. Reset mid-operation discards every in-flight op; no output for them ever appears.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en; in_ready is combinational from out_ready and registered state only, never from in_valid.
- When en=1, all stages shift by one; stage 0 captures the input and its valid bit = in_valid. When en=0, all stages hold, including bubbles (no bubble collapsing).
- Latency: an op accepted at edge t appears with out_valid=1 after edge t+NUM_STAGE−1, provided en stays 1. Throughput is 1 op/cycle.
- Arithmetic: product = signed(in_a) × signed({1'b0,in_b}); exact in P_W bits. Sign-extend to ACC_W as ext_p. Internal stage split is free as long as latency is exact.
- Final stage, on capture of a valid op:
  - MUL: out_data = ext_p; acc_q unchanged.
  - MAC: base = in_clr ? 0 : acc_q; out_data = base + ext_p; acc_q ← same value.
  - Addition wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Consecutive MAC ops in flight accumulate in acceptance order. The accumulator updates exactly once per valid MAC op reaching the final stage. It is never updated by bubbles or while stalled.
- out_data, out_tag and out_valid are registers. They hold stable while out_valid & ~out_ready.
- in_clr is ignored in MUL mode.
- Simultaneous output and input handshakes in the same cycle are legal and lossless.
- NUM_STAGE=1: the final stage is stage 0 and out_* is registered directly from the inputs.

Decomposition:
- Shared package astar_pkg holds:
  - mode constants MODE_MUL=1'b0, MODE_MAC=1'b1;
  - default width constants A_W/B_W/ACC_W;
  - typedef mul_op_t = {mode, clr, tag}, carried per stage.
- One sub-module is natural: astar_pipe_ctrl, holding the stage valid-bit shift register and en/in_ready generation. The multiplier data path stays in the top level so synthesis can infer DSP48 with pipeline registers.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 → out_valid=0, acc_q=0, in_ready=1 after deassert; no result emerges for inputs offered during reset.
- MUL boundary: a=−1 (0x7FFF), b=0x3FFFFF, tag=0x5A → exactly NUM_STAGE cycles later out_data=−4194303 (sign-extended 48b), out_tag=0x5A.
- MAC chain: back-to-back (3,4,clr=1), (−2,5,clr=0), (7,1,clr=0) → outputs 12, 2, 9; acc_q=9; a following MUL (2,2) outputs 4 with acc_q still 9.
- Backpressure: stream 10 ops with out_ready toggling randomly → in-order results, no loss or duplication, out_data stable while stalled, in_ready=0 exactly when out_valid & ~out_ready.
- Wrap: ACC_W=P_W=37; MAC a=0x3FFF, b=0x3FFFFF repeated until sum exceeds 2^36−1 → result wraps modulo 2^37, matching a reference model.
- Reset mid-stream: assert reset while 3 MAC ops are in flight → no outputs appear; acc_q=0; the next MAC (1,1,clr=0) outputs 1.
